// File: rtl/led_run_ctrl.sv
// rtl/led_run_ctrl.sv - running-light LED sequencer with one shared step timer
// Modes: run, bounce, blink-all, hold; the lit LED pulses inside [ON_LO, ON_HI) of each step.
module led_run_ctrl #(
  parameter int          N_LED    = 4,
  parameter logic [22:0] STEP_CNT = 23'd20,
  parameter logic [22:0] ON_LO    = 23'd10,
  parameter logic [22:0] ON_HI    = 23'd15
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             Dir,
  output logic [N_LED-1:0] LED_Out,
  output logic [2:0]       Pos,
  output logic             Step_Done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    BOUNCE = 3'd2,
    BLINK  = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [2:0]       LAST    = 3'(N_LED - 1);
  localparam logic [N_LED-1:0] LED_ONE = {{(N_LED-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [22:0]      count, count_nxt;
  logic [2:0]       pos_nxt;
  logic             bdir, bdir_nxt;
  logic             phase, phase_nxt;
  logic [N_LED-1:0] led_nxt;

  function automatic state_t mode_to_state(input logic [1:0] m);
    case (m)
      2'b00:   return RUN;
      2'b01:   return BOUNCE;
      2'b10:   return BLINK;
      default: return HOLD;
    endcase
  endfunction

  state_t           mode_state;
  logic             stepping;
  logic             step_end;
  logic             in_window;
  logic [N_LED-1:0] pos_led;
  logic [N_LED-1:0] blink_led;
  logic [2:0]       pos_inc;
  logic [2:0]       pos_dec;
  logic [2:0]       run_pos;
  logic             bounce_up;
  logic [2:0]       bounce_pos;
  logic             bounce_dir;

  assign mode_state = mode_to_state(Mode);
  assign stepping   = (state == RUN) || (state == BOUNCE) || (state == BLINK);
  assign step_end   = stepping && (count == STEP_CNT);
  assign Step_Done  = step_end;
  assign in_window  = (count >= ON_LO) && (count < ON_HI);
  assign pos_led    = in_window ? (LED_ONE << Pos) : '0;
  assign blink_led  = (in_window && !phase) ? {N_LED{1'b1}} : '0;

  assign pos_inc = Pos + 3'd1;
  assign pos_dec = Pos - 3'd1;
  assign run_pos = Dir ? ((Pos == 3'd0) ? LAST : pos_dec)
                       : ((Pos >= LAST) ? 3'd0 : pos_inc);

  // Turn around at the ends so the end LEDs are never lit twice in a row.
  assign bounce_up  = bdir ? (Pos == 3'd0) : (Pos < LAST);
  assign bounce_pos = bounce_up ? pos_inc : pos_dec;
  assign bounce_dir = bounce_up ? (pos_inc == LAST) : (pos_dec != 3'd0);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      count     <= '0;
      Pos       <= '0;
      bdir      <= 1'b0;
      phase     <= 1'b0;
      LED_Out   <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      Pos       <= pos_nxt;
      bdir      <= bdir_nxt;
      phase     <= phase_nxt;
      LED_Out   <= led_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pos_nxt   = Pos;
    bdir_nxt  = bdir;
    phase_nxt = phase;
    led_nxt   = LED_Out;

    if (!En) begin
      state_nxt = IDLE;
      count_nxt = '0;
      pos_nxt   = '0;
      led_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          count_nxt = '0;
          led_nxt   = '0;
          state_nxt = mode_state;
          case (mode_state)
            RUN:    pos_nxt   = Dir ? LAST : 3'd0;
            BOUNCE: begin
              pos_nxt  = 3'd0;
              bdir_nxt = 1'b0;
            end
            BLINK:  phase_nxt = 1'b0;
            default: ;
          endcase
        end

        RUN, BOUNCE, BLINK: begin
          led_nxt = (state == BLINK) ? blink_led : pos_led;
          if (step_end) begin
            count_nxt = '0;
            if (mode_state == state) begin
              case (state)
                RUN:    pos_nxt   = run_pos;
                BOUNCE: begin
                  pos_nxt  = bounce_pos;
                  bdir_nxt = bounce_dir;
                end
                default: phase_nxt = !phase;
              endcase
            end else begin
              // A mode change replaces this step's advance with the new mode's entry values.
              state_nxt = mode_state;
              case (mode_state)
                RUN:    pos_nxt   = Dir ? LAST : 3'd0;
                BOUNCE: begin
                  pos_nxt  = 3'd0;
                  bdir_nxt = 1'b0;
                end
                BLINK:  phase_nxt = 1'b0;
                default: ;
              endcase
            end
          end else begin
            count_nxt = count + 23'd1;
          end
        end

        HOLD: begin
          if (mode_state != HOLD) begin
            state_nxt = mode_state;
            count_nxt = '0;
            case (mode_state)
              BOUNCE: bdir_nxt  = (Pos == LAST);
              BLINK:  phase_nxt = 1'b0;
              default: ;
            endcase
          end
        end

        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
          pos_nxt   = '0;
          led_nxt   = '0;
        end
      endcase
    end
  end

endmodule
